// File: rtl/bnn_binarize_pack_pkg.sv
// Shared BNN definitions: layer dimensions and the packed binary activation type
// consumed by the accumulation layer.
package bnn_binarize_pack_pkg;

    localparam int BNN_OUT_DIM     = 4;
    localparam int BNN_CHANNEL_CNT = 4;
    localparam int BNN_BIT_WIDTH   = 8;

    // Bit [n][c] is the activation of neuron n for beat c.
    typedef logic [BNN_OUT_DIM-1:0][BNN_CHANNEL_CNT-1:0] bnn_act_pack_t;

endpackage

// File: rtl/bnn_threshold_cmp.sv
// One neuron binarizer: signed threshold compare, optionally inverted to
// absorb a negative batch-norm gamma.
module bnn_threshold_cmp
    import bnn_binarize_pack_pkg::*;
#(
    parameter int BIT_WIDTH = BNN_BIT_WIDTH
) (
    input  logic signed [BIT_WIDTH-1:0] value,
    input  logic signed [BIT_WIDTH-1:0] thr,
    input  logic                        flip,
    output logic                        act
);

    // Full-width two's-complement compare, no saturation.
    assign act = (value >= thr) ^ flip;

endmodule

// File: rtl/bnn_binarize_pack.sv
// Binarizes per-neuron accumulator beats against programmable thresholds and
// packs CHANNEL_CNT beats into one word for the next layer.
//
// state        | meaning
// cnt_q        | column the next accepted beat is written to
// out_valid_q  | output register holds a word waiting for downstream
module bnn_binarize_pack
    import bnn_binarize_pack_pkg::*;
#(
    parameter int OUT_DIM     = BNN_OUT_DIM,
    parameter int CHANNEL_CNT = BNN_CHANNEL_CNT,
    parameter int BIT_WIDTH   = BNN_BIT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OUT_DIM*BIT_WIDTH-1:0]   in_data,
    input  logic                           thr_we,
    input  logic [$clog2(OUT_DIM)-1:0]     thr_addr,
    input  logic [BIT_WIDTH-1:0]           thr_data,
    input  logic                           thr_flip,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_DIM*CHANNEL_CNT-1:0] out_data
);

    localparam int             AW       = $clog2(OUT_DIM);
    localparam int             CW       = (CHANNEL_CNT > 1) ? $clog2(CHANNEL_CNT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CHANNEL_CNT - 1);

    logic [CW-1:0]                         cnt_q, cnt_d;
    logic [OUT_DIM-1:0][CHANNEL_CNT-1:0]   pack_q, pack_d;
    logic [OUT_DIM-1:0][CHANNEL_CNT-1:0]   out_q, out_d;
    logic                                  out_valid_q, out_valid_d;
    logic [OUT_DIM-1:0][BIT_WIDTH-1:0]     thr_q, thr_d;
    logic [OUT_DIM-1:0]                    flip_q, flip_d;

    logic [OUT_DIM-1:0] beat_bits;
    logic               last_beat;
    logic               beat_fire;
    logic               word_fire;
    logic               thr_addr_ok;

    // One comparator per neuron, always using the currently stored threshold.
    for (genvar g = 0; g < OUT_DIM; g++) begin : g_cmp
        bnn_threshold_cmp #(
            .BIT_WIDTH (BIT_WIDTH)
        ) u_cmp (
            .value (in_data[g*BIT_WIDTH +: BIT_WIDTH]),
            .thr   (thr_q[g]),
            .flip  (flip_q[g]),
            .act   (beat_bits[g])
        );
    end

    // Out-of-range addresses can only exist when OUT_DIM is not a power of two.
    if ((1 << AW) == OUT_DIM) begin : g_addr_full
        assign thr_addr_ok = 1'b1;
    end else begin : g_addr_part
        assign thr_addr_ok = (32'(thr_addr) < OUT_DIM);
    end

    assign last_beat = (cnt_q == CNT_LAST);
    // Only the closing beat needs a free output slot; earlier beats keep filling.
    assign in_ready  = !clr && !(last_beat && out_valid_q && !out_ready);
    assign beat_fire = in_valid && in_ready;
    assign word_fire = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    // Column counter, pack register and output register next state.
    always_comb begin
        cnt_d       = cnt_q;
        pack_d      = pack_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (word_fire) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (beat_fire) begin
            for (int n = 0; n < OUT_DIM; n++) begin
                pack_d[n][cnt_q] = beat_bits[n];
            end
            if (last_beat) begin
                // Load overrides a same-cycle drain, so valid stays high without a bubble.
                out_d       = pack_d;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                pack_d      = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Threshold and flip table next state.
    always_comb begin
        thr_d  = thr_q;
        flip_d = flip_q;
        if (thr_we && thr_addr_ok) begin
            thr_d[thr_addr]  = thr_data;
            flip_d[thr_addr] = thr_flip;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            pack_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            thr_q       <= '0;
            flip_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pack_q      <= pack_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            thr_q       <= thr_d;
            flip_q      <= flip_d;
        end
    end

endmodule

// File: tb/tb_bnn_binarize_pack.sv
// Self-checking bench for bnn_binarize_pack with a behavioural packing model.
module tb_bnn_binarize_pack;

    localparam int OD = 4;
    localparam int CC = 4;
    localparam int BW = 8;
    localparam int DW = OD * BW;
    localparam int PW = OD * CC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          thr_we;
    logic [1:0]    thr_addr;
    logic [BW-1:0] thr_data;
    logic          thr_flip;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int thr_m  [OD];
    bit flip_m [OD];

    bnn_binarize_pack #(
        .OUT_DIM     (OD),
        .CHANNEL_CNT (CC),
        .BIT_WIDTH   (BW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .thr_we    (thr_we),
        .thr_addr  (thr_addr),
        .thr_data  (thr_data),
        .thr_flip  (thr_flip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] mk_beat(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [OD-1:0] model_col(input logic [DW-1:0] d);
        logic [OD-1:0]        col;
        logic signed [BW-1:0] s;
        int                   v;
        col = '0;
        for (int n = 0; n < OD; n++) begin
            s = d[n*BW +: BW];
            v = int'(s);
            col[n] = ((v >= thr_m[n]) != flip_m[n]);
        end
        return col;
    endfunction

    function automatic logic [PW-1:0] place(input logic [PW-1:0] w, input logic [OD-1:0] col, input int k);
        for (int n = 0; n < OD; n++) w[n*CC + k] = col[n];
        return w;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < OD; n++) begin
            thr_m[n]  = 0;
            flip_m[n] = 1'b0;
        end
    endtask

    // ---------------- drivers (entered and left at posedge+1) ----------------
    task automatic idle_inputs();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        thr_we   = 1'b0;
        thr_addr = '0;
        thr_data = '0;
        thr_flip = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic write_thr(input logic [1:0] a, input logic signed [BW-1:0] t, input logic f);
        thr_we   = 1'b1;
        thr_addr = a;
        thr_data = t;
        thr_flip = f;
        @(posedge clk); #1;
        thr_we      = 1'b0;
        thr_m[a]    = int'(t);
        flip_m[a]   = f;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_pattern();
        logic [DW-1:0] d;
        logic [PW-1:0] exp;
        bit            ok;
        int            acc;
        out_ready = 1'b1;
        d   = mk_beat(5, -1, 0, -128);
        exp = '0;
        acc = 0;
        for (int k = 0; k < CC; k++) begin
            exp = place(exp, model_col(d), k);
            if (k == CC - 1) begin
                total_cnt++;
                if (out_valid !== 1'b0) $display("FAIL basic_early_valid got=%0b exp=0", out_valid);
                else pass_cnt++;
            end
            send_beat(d, ok);
            acc += int'(ok);
        end
        total_cnt++;
        if (acc != CC) $display("FAIL basic_beats_accepted got=%0d exp=%0d", acc, CC);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL basic_valid_latency got=%0b exp=1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== exp) $display("FAIL basic_word got=%h exp=%h", out_data, exp);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL basic_drain got=%0b exp=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_thr_flip();
        logic [DW-1:0] d;
        logic [PW-1:0] exp;
        bit            ok;
        out_ready = 1'b1;
        write_thr(2'd1, -8'sd2, 1'b0);
        write_thr(2'd3, 8'sd0, 1'b1);
        d   = mk_beat(0, -2, -3, 127);
        exp = '0;
        for (int k = 0; k < CC; k++) begin
            exp = place(exp, model_col(d), k);
            send_beat(d, ok);
        end
        total_cnt++;
        if ({out_data[3*CC], out_data[2*CC], out_data[CC], out_data[0]} !== 4'b0011)
            $display("FAIL thrflip_col0 got=%b exp=0011",
                     {out_data[3*CC], out_data[2*CC], out_data[CC], out_data[0]});
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp)
            $display("FAIL thrflip_word got=%0b/%h exp=1/%h", out_valid, out_data, exp);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_thr_same_cycle();
        logic [DW-1:0] d;
        logic [PW-1:0] exp;
        bit            ok;
        apply_reset();
        out_ready = 1'b1;
        d   = mk_beat(10, 10, 10, 10);
        exp = place('0, model_col(d), 0);
        in_valid = 1'b1;
        in_data  = d;
        thr_we   = 1'b1;
        thr_addr = 2'd0;
        thr_data = 8'd50;
        thr_flip = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL samecyc_ready got=%0b exp=1", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        thr_we   = 1'b0;
        thr_m[0] = 50;
        for (int k = 1; k < CC; k++) begin
            exp = place(exp, model_col(d), k);
            send_beat(d, ok);
        end
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp)
            $display("FAIL samecyc_word got=%0b/%h exp=1/%h", out_valid, out_data, exp);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d;
        logic [PW-1:0] exp_a, exp_b;
        bit            ok;
        out_ready = 1'b0;
        exp_a = '0;
        exp_b = '0;
        for (int k = 0; k < CC; k++) begin
            d = $urandom;
            exp_a = place(exp_a, model_col(d), k);
            send_beat(d, ok);
        end
        for (int k = 0; k < CC - 1; k++) begin
            d = $urandom;
            exp_b = place(exp_b, model_col(d), k);
            send_beat(d, ok);
        end
        d = $urandom;
        exp_b = place(exp_b, model_col(d), CC - 1);
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++;
            if (in_ready !== 1'b0) $display("FAIL bp_stall_ready cyc=%0d got=%0b exp=0", i, in_ready);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1 || out_data !== exp_a)
                $display("FAIL bp_hold cyc=%0d got=%0b/%h exp=1/%h", i, out_valid, out_data, exp_a);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%0b exp=1", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp_b)
            $display("FAIL bp_second_word got=%0b/%h exp=1/%h", out_valid, out_data, exp_b);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain got=%0b exp=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] d;
        logic [PW-1:0] exp_a, exp_b;
        bit            ok;
        out_ready = 1'b0;
        exp_a = '0;
        exp_b = '0;
        for (int k = 0; k < CC; k++) begin
            d = $urandom;
            exp_a = place(exp_a, model_col(d), k);
            send_beat(d, ok);
        end
        for (int k = 0; k < CC - 1; k++) begin
            d = $urandom;
            exp_b = place(exp_b, model_col(d), k);
            send_beat(d, ok);
        end
        d = $urandom;
        exp_b = place(exp_b, model_col(d), CC - 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== exp_a)
            $display("FAIL simul_pre got=%0b/%0b/%h exp=1/1/%h", in_ready, out_valid, out_data, exp_a);
        else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp_b)
            $display("FAIL simul_no_bubble got=%0b/%h exp=1/%h", out_valid, out_data, exp_b);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_clr();
        logic [DW-1:0] d;
        logic [PW-1:0] exp;
        bit            ok;
        apply_reset();
        out_ready = 1'b1;
        send_beat(mk_beat(1, 1, 1, 1), ok);
        send_beat(mk_beat(1, 1, 1, 1), ok);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = mk_beat(1, 1, 1, 1);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL clr_ready got=%0b exp=0", in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        exp = '0;
        for (int k = 0; k < CC; k++) begin
            d = mk_beat((k == 1) ? 1 : -1, (k == 2) ? 1 : -1, (k == 3) ? 1 : -1, -1);
            exp = place(exp, model_col(d), k);
            if (k == CC - 1) begin
                total_cnt++;
                if (out_valid !== 1'b0) $display("FAIL clr_early_word got=%0b exp=0", out_valid);
                else pass_cnt++;
            end
            send_beat(d, ok);
        end
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp)
            $display("FAIL clr_word got=%0b/%h exp=1/%h", out_valid, out_data, exp);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midword();
        logic [DW-1:0] d;
        logic [PW-1:0] exp;
        bit            ok;
        write_thr(2'd2, 8'sd20, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < CC + 2; k++) send_beat(logic'($urandom) ? mk_beat(3, 4, 5, 6) : 32'h0, ok);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== '0)
            $display("FAIL midrst_async got=%0b/%h exp=0/0", out_valid, out_data);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        exp = '0;
        for (int k = 0; k < CC; k++) begin
            d = mk_beat(-k, k - 1, 2 - k, -1);
            exp = place(exp, model_col(d), k);
            if (k == CC - 1) begin
                total_cnt++;
                if (out_valid !== 1'b0) $display("FAIL midrst_early_word got=%0b exp=0", out_valid);
                else pass_cnt++;
            end
            send_beat(d, ok);
        end
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== exp)
            $display("FAIL midrst_word got=%0b/%h exp=1/%h", out_valid, out_data, exp);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [PW-1:0] q[$];
        logic [PW-1:0] w, exp;
        int            k;
        apply_reset();
        for (int n = 0; n < OD; n++) write_thr(2'(n), 8'($urandom), 1'($urandom));
        w = '0;
        k = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            in_valid  = 1'($urandom);
            in_data   = $urandom;
            thr_we    = ($urandom_range(0, 15) == 0);
            thr_addr  = 2'($urandom_range(0, 3));
            thr_data  = 8'($urandom);
            thr_flip  = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL rand_unexpected_word got=%h", out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp) $display("FAIL rand_word cyc=%0d got=%h exp=%h", cyc, out_data, exp);
                    else pass_cnt++;
                end
            end
            if (clr) begin
                w = '0;
                k = 0;
            end else if (in_valid && in_ready) begin
                w = place(w, model_col(in_data), k);
                k++;
                if (k == CC) begin
                    q.push_back(w);
                    w = '0;
                    k = 0;
                end
            end
            if (thr_we) begin
                thr_m[thr_addr]  = int'($signed(thr_data));
                flip_m[thr_addr] = thr_flip;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL rand_drain_extra got=%h", out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp) $display("FAIL rand_drain_word got=%h exp=%h", out_data, exp);
                    else pass_cnt++;
                end
            end
            @(posedge clk); #1;
        end
        total_cnt++;
        if (q.size() != 0) $display("FAIL rand_lost_words got=%0d exp=0", q.size());
        else pass_cnt++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_pattern();
        test_thr_flip();
        test_thr_same_cycle();
        test_backpressure();
        test_simultaneous();
        test_clr();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
